data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// CPU data-port bundle for data_mem_responder: request/store lines from the CPU,
// load data, completion pulse and sticky error back from the memory side.
interface data_mem_responder_if;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] MemReadData;
   logic        MemReady;
   logic        MemError;

   modport master (
      output MemAddress, MemWriteData, MemRead, MemWrite,
      input  MemReadData, MemReady, MemError
   );

   modport slave (
      input  MemAddress, MemWriteData, MemRead, MemWrite,
      output MemReadData, MemReady, MemError
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle ready pulse.
// Optional DMEM_STATS_EN adds ReadCount/WriteCount outputs for legal completed accesses.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   data_mem_responder_if.slave  bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]          ReadCount,
   output logic [15:0]          WriteCount
`endif
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        is_write_q, is_write_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
`ifdef DMEM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;
`endif

   logic [31:0]   mem [DEPTH_WORDS];
   logic          legal;
   logic          commit;
   logic [AW-1:0] word_idx;

   assign legal    = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < DEPTH_LIM);
   assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
   assign word_idx = addr_q[AW+1:2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      error_d    = error_q;
`ifdef DMEM_STATS_EN
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.MemRead ^ bus.MemWrite) begin
               addr_d     = bus.MemAddress;
               wdata_d    = bus.MemWriteData;
               is_write_d = bus.MemWrite;
               cnt_d      = WAIT_INIT;
               state_d    = ST_WAIT;
            end else if (bus.MemRead && bus.MemWrite) begin
               error_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!is_write_q) begin
                  rdata_d = legal ? mem[word_idx] : 32'd0;
               end
               if (!legal) begin
                  error_d = 1'b1;
               end
`ifdef DMEM_STATS_EN
               if (legal && is_write_q) wr_count_d = wr_count_q + 16'd1;
               if (legal && !is_write_q) rd_count_d = rd_count_q + 16'd1;
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            // Ready is registered, so it is seen in the cycle after DONE.
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         is_write_q <= 1'b0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
`ifdef DMEM_STATS_EN
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
`ifdef DMEM_STATS_EN
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
`endif
      end
   end

   // Storage is never reset; a reset mid-WAIT leaves state_q in IDLE so no commit happens.
   always_ff @(posedge Clk) begin
      if (commit && is_write_q && legal) begin
         mem[word_idx] <= wdata_q;
      end
   end

   assign bus.MemReadData = rdata_q;
   assign bus.MemReady    = ready_q;
   assign bus.MemError    = error_q;
`ifdef DMEM_STATS_EN
   assign ReadCount  = rd_count_q;
   assign WriteCount = wr_count_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one WAIT_STATES=2 instance for function and
// error cases, one WAIT_STATES=0 instance for back-to-back throughput.
module tb_data_mem_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

`ifdef DMEM_STATS_EN
   logic [15:0] rc_a, wc_a, rc_b, wc_b;
`endif

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
      .Clk        (clk),
      .Rst        (rst),
      .bus        (bus_a)
`ifdef DMEM_STATS_EN
      ,
      .ReadCount  (rc_a),
      .WriteCount (wc_a)
`endif
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
      .Clk        (clk),
      .Rst        (rst),
      .bus        (bus_b)
`ifdef DMEM_STATS_EN
      ,
      .ReadCount  (rc_b),
      .WriteCount (wc_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns edges from accept to ready and the ready level one cycle later.
   task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic ready_after);
      bus_a.MemRead      = rd;
      bus_a.MemWrite     = wr;
      bus_a.MemAddress   = addr;
      bus_a.MemWriteData = wdata;
      @(posedge clk); #1;
      bus_a.MemRead  = 1'b0;
      bus_a.MemWrite = 1'b0;
      bus_a.MemAddress   = 32'hFFFF_FFFF;
      bus_a.MemWriteData = 32'h5555_5555;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus_a.MemReady) begin
            lat = k;
            break;
         end
      end
      @(posedge clk); #1;
      ready_after = bus_a.MemReady;
      $display("A rd=%0d wr=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
               rd, wr, addr, wdata, lat, bus_a.MemReadData, bus_a.MemError);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   int   lat;
   logic rdy_after;
   int   seen_ready;
   int   last_pulse;
   int   npulse;
   int   stable_bad;
   logic [31:0] hold_data;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
      bus_a.MemAddress = 32'd0; bus_a.MemWriteData = 32'd0;
      bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0;
      bus_b.MemAddress = 32'd0; bus_b.MemWriteData = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", bus_a.MemReadData, 32'd0);
      check("rst_ready", {31'd0, bus_a.MemReady}, 32'd0);
      check("rst_error", {31'd0, bus_a.MemError}, 32'd0);
      check("rst_ready_b", {31'd0, bus_b.MemReady}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      access_a(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rdy_after);
      check("wr10_lat", lat, 4);
      check("wr10_onecycle", {31'd0, rdy_after}, 32'd0);
      check("wr10_err", {31'd0, bus_a.MemError}, 32'd0);

      access_a(1'b1, 1'b0, 32'h10, 32'd0, lat, rdy_after);
      check("rd10_lat", lat, 4);
      check("rd10_data", bus_a.MemReadData, 32'hDEAD_BEEF);
      check("rd10_err", {31'd0, bus_a.MemError}, 32'd0);

      access_a(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, lat, rdy_after);
      access_a(1'b0, 1'b1, 32'h00, 32'h1111_1111, lat, rdy_after);
      check("rd10_hold", bus_a.MemReadData, 32'hDEAD_BEEF);

      // Reset one cycle after accepting a write must abort it.
      bus_a.MemWrite = 1'b1; bus_a.MemAddress = 32'h20; bus_a.MemWriteData = 32'h0000_1234;
      @(posedge clk); #1;
      bus_a.MemWrite = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort_rdata", bus_a.MemReadData, 32'd0);
      check("abort_ready", {31'd0, bus_a.MemReady}, 32'd0);
      check("abort_error", {31'd0, bus_a.MemError}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      access_a(1'b1, 1'b0, 32'h20, 32'd0, lat, rdy_after);
      check("abort_rd20", bus_a.MemReadData, 32'hCAFE_F00D);

      // Both strobes high: no access, error set.
      seen_ready = 0;
      bus_a.MemRead = 1'b1; bus_a.MemWrite = 1'b1; bus_a.MemAddress = 32'h10;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus_a.MemReady) seen_ready++;
      end
      bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
      check("both_noready", seen_ready, 0);
      check("both_error", {31'd0, bus_a.MemError}, 32'd1);
      access_a(1'b1, 1'b0, 32'h10, 32'd0, lat, rdy_after);
      check("both_idle_lat", lat, 4);
      check("both_sticky", {31'd0, bus_a.MemError}, 32'd1);

      pulse_rst();
      check("clr_error", {31'd0, bus_a.MemError}, 32'd0);

      access_a(1'b1, 1'b0, 32'h10, 32'd0, lat, rdy_after);
      check("prime_data", bus_a.MemReadData, 32'hDEAD_BEEF);
      access_a(1'b1, 1'b0, 32'h13, 32'd0, lat, rdy_after);
      check("mis_lat", lat, 4);
      check("mis_data", bus_a.MemReadData, 32'd0);
      check("mis_error", {31'd0, bus_a.MemError}, 32'd1);
      access_a(1'b1, 1'b0, 32'h10, 32'd0, lat, rdy_after);
      check("mis_then_legal", bus_a.MemReadData, 32'hDEAD_BEEF);
      check("mis_sticky", {31'd0, bus_a.MemError}, 32'd1);
      access_a(1'b0, 1'b1, 32'h1000, 32'hBADB_AD00, lat, rdy_after);
      check("oor_wr_lat", lat, 4);
      access_a(1'b1, 1'b0, 32'h1000, 32'd0, lat, rdy_after);
      check("oor_rd_lat", lat, 4);
      check("oor_rd_data", bus_a.MemReadData, 32'd0);
      access_a(1'b1, 1'b0, 32'h0, 32'd0, lat, rdy_after);
      check("oor_word0", bus_a.MemReadData, 32'h1111_1111);
      check("oor_sticky", {31'd0, bus_a.MemError}, 32'd1);

      // WAIT_STATES=0 instance: single write, then a continuously held read.
      bus_b.MemWrite = 1'b1; bus_b.MemAddress = 32'h8; bus_b.MemWriteData = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      bus_b.MemWrite = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (bus_b.MemReady) begin
            lat = k;
            break;
         end
      end
      check("b_wr_lat", lat, 2);
      @(posedge clk); #1;
      bus_b.MemRead = 1'b1; bus_b.MemAddress = 32'h8;
      last_pulse = -1;
      npulse = 0;
      stable_bad = 0;
      hold_data = 32'd0;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         @(posedge clk); #1;
         if (npulse > 0 && bus_b.MemReadData !== hold_data) stable_bad++;
         if (bus_b.MemReady) begin
            if (last_pulse >= 0) check("b_period", cyc - last_pulse, 3);
            else check("b_first", cyc, 3);
            check("b_rdata", bus_b.MemReadData, 32'hA5A5_A5A5);
            hold_data = bus_b.MemReadData;
            last_pulse = cyc;
            npulse++;
         end
      end
      bus_b.MemRead = 1'b0;
      $display("B held read pulses=%0d unstable=%0d", npulse, stable_bad);
      check("b_pulses", npulse, 5);
      check("b_stable", stable_bad, 0);

`ifdef DMEM_STATS_EN
      pulse_rst();
      check("stats_rst_rc", {16'd0, rc_a}, 32'd0);
      check("stats_rst_wc", {16'd0, wc_a}, 32'd0);
      access_a(1'b0, 1'b1, 32'h40, 32'h1, lat, rdy_after);
      access_a(1'b0, 1'b1, 32'h44, 32'h2, lat, rdy_after);
      access_a(1'b0, 1'b1, 32'h48, 32'h3, lat, rdy_after);
      access_a(1'b1, 1'b0, 32'h40, 32'd0, lat, rdy_after);
      access_a(1'b1, 1'b0, 32'h44, 32'd0, lat, rdy_after);
      access_a(1'b1, 1'b0, 32'h41, 32'd0, lat, rdy_after);
      check("stats_wc", {16'd0, wc_a}, 32'd3);
      check("stats_rc", {16'd0, rc_a}, 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
